// File: rtl/attn_pkg.sv
// Shared types and sizes for the attention output collector.
package attn_pkg;

  localparam int VEC_W   = 128;
  localparam int ROW_W   = 2;
  localparam int TILE_W  = 5;
  localparam int IDX_W   = ROW_W + TILE_W;
  localparam int N_ROWS  = 4;
  localparam int N_TILES = 32;
  localparam int N_VEC   = 128;

  // One streamed result vector tagged with its matrix position.
  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [TILE_W-1:0] tile;
    logic [VEC_W-1:0]  vec;
  } attn_vec_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Flat bitmap / address index of a vector: {row, tile}.
  function automatic logic [IDX_W-1:0] vec_index(input attn_vec_t e);
    return {e.row, e.tile};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with async clear and a synchronous flush.
// Storage is a plain array; the head entry is presented combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update: clear and flush empty the queue, otherwise advance on push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/attn_out_collector.sv
// Collects tagged GEMM result vectors, writes them to the output SRAM and
// tracks per-row and whole-matrix completion plus overflow/duplicate flags.
module attn_out_collector
  import attn_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] O_BASE     = 7'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in_vec,
  input  logic [1:0]   in_row,
  input  logic [4:0]   in_tile,
  input  logic         in_valid,
  output logic [6:0]   O_mem_addr,
  output logic [127:0] O_mem_din,
  output logic         O_mem_we,
  input  logic         O_mem_ready,
  output logic [3:0]   row_done,
  output logic         all_done,
  output logic         busy,
  output logic         overflow,
  output logic         dup_err
);

  state_t            state;
  logic              collecting;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;
  attn_vec_t         fifo_din;
  attn_vec_t         fifo_dout;
  logic [IDX_W-1:0]  wr_idx;
  logic              dup_hit;
  logic [N_VEC-1:0]  bitmap;
  logic [N_VEC-1:0]  bitmap_next;
  logic [N_ROWS-1:0] row_full;
  logic [7:0]        count;

  // start wins over everything else in the same cycle.
  assign collecting = (state == S_COLLECT) && !start;
  assign fifo_pop   = collecting && !fifo_empty && O_mem_ready;
  assign fifo_push  = collecting && in_valid && (!fifo_full || fifo_pop);
  assign drop       = collecting && in_valid && fifo_full && !fifo_pop;

  assign fifo_din = '{row: in_row, tile: in_tile, vec: in_vec};

  sync_fifo #(
    .WIDTH($bits(attn_vec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(start),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign wr_idx  = vec_index(fifo_dout);
  assign dup_hit = bitmap[wr_idx];

  // Bitmap as it will look after this cycle's write, used for row completion.
  always_comb begin
    bitmap_next = bitmap;
    if (fifo_pop) bitmap_next[wr_idx] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row
      assign row_full[gi] = &bitmap_next[gi*N_TILES +: N_TILES];
    end
  endgenerate

  // Registered SRAM write port: one write per popped entry, address wraps mod 128.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O_mem_we   <= 1'b0;
      O_mem_addr <= '0;
      O_mem_din  <= '0;
    end else begin
      O_mem_we <= fifo_pop;
      if (fifo_pop) begin
        O_mem_addr <= O_BASE + wr_idx;
        O_mem_din  <= fifo_dout.vec;
      end
    end
  end

  // Completion bookkeeping: bitmap, unique-write count, row_done and dup_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap   <= '0;
      count    <= '0;
      row_done <= '0;
      dup_err  <= 1'b0;
    end else if (start) begin
      bitmap   <= '0;
      count    <= '0;
      row_done <= '0;
      dup_err  <= 1'b0;
    end else if (fifo_pop) begin
      bitmap   <= bitmap_next;
      row_done <= row_full;
      if (dup_hit) dup_err <= 1'b1;
      else         count   <= count + 8'd1;
    end
  end

  // Sticky loss flag for vectors that arrived while the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        overflow <= 1'b0;
    else if (start) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

  // Pass sequencing: idle -> collect until 128 unique writes -> done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      all_done <= 1'b0;
    end else begin
      all_done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        state <= S_COLLECT;
      end else begin
        case (state)
          S_COLLECT: if (count == 8'(N_VEC)) state <= S_DONE;
          S_DONE: begin
            all_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_attn_out_collector.sv
// Directed + random bench for attn_out_collector with a queue-based reference.
module tb_attn_out_collector;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_COLLECT = 1, P_DONE = 2;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, O_mem_ready;
  logic [127:0] in_vec;
  logic [1:0]   in_row;
  logic [4:0]   in_tile;

  logic [6:0]   addr_a, addr_b;
  logic [127:0] din_a, din_b;
  logic         we_a, we_b, done_a, done_b, busy_a, busy_b;
  logic         ovf_a, ovf_b, dup_a, dup_b;
  logic [3:0]   rowd_a, rowd_b;

  always #5 clk = ~clk;

  attn_out_collector #(.FIFO_DEPTH(DEPTH), .O_BASE(7'd0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .in_row(in_row),
    .in_tile(in_tile), .in_valid(in_valid), .O_mem_addr(addr_a), .O_mem_din(din_a),
    .O_mem_we(we_a), .O_mem_ready(O_mem_ready), .row_done(rowd_a), .all_done(done_a),
    .busy(busy_a), .overflow(ovf_a), .dup_err(dup_a)
  );

  attn_out_collector #(.FIFO_DEPTH(DEPTH), .O_BASE(7'd64)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .in_row(in_row),
    .in_tile(in_tile), .in_valid(in_valid), .O_mem_addr(addr_b), .O_mem_din(din_b),
    .O_mem_we(we_b), .O_mem_ready(O_mem_ready), .row_done(rowd_b), .all_done(done_b),
    .busy(busy_b), .overflow(ovf_b), .dup_err(dup_b)
  );

  // Reference model state
  typedef struct { logic [6:0] idx; logic [127:0] d; } ent_t;
  ent_t         q[$];
  bit           seen [128];
  int           cnt, phase;
  logic         m_we, m_done, m_busy, m_ovf, m_dup;
  logic [3:0]   m_rowd;
  logic [6:0]   m_idx;
  logic [127:0] m_din;

  int total = 0, bad = 0;
  int done_seen = 0, writes_seen = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    foreach (seen[i]) seen[i] = 0;
    cnt = 0; m_rowd = '0; m_ovf = 0; m_dup = 0;
  endtask

  // One clock: drive inputs, advance model, then compare after the edge.
  task automatic step(input logic v, input logic [1:0] r, input logic [4:0] t,
                      input logic [127:0] d, input logic rdy, input logic st);
    int   cb;
    ent_t e;
    bit   all;
    in_valid = v; in_row = r; in_tile = t; in_vec = d; O_mem_ready = rdy; start = st;
    m_we = 0; m_done = 0;
    if (st) begin
      model_clear();
      m_busy = 1; phase = P_COLLECT;
    end else if (phase == P_COLLECT) begin
      cb = cnt;
      if (q.size() > 0 && rdy) begin
        e = q.pop_front();
        m_we = 1; m_idx = e.idx; m_din = e.d;
        if (seen[e.idx]) m_dup = 1;
        else begin seen[e.idx] = 1; cnt++; end
        for (int i = 0; i < 4; i++) begin
          all = 1;
          for (int j = 0; j < 32; j++) if (!seen[i*32+j]) all = 0;
          m_rowd[i] = all;
        end
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back('{idx: {r, t}, d: d});
        else m_ovf = 1;
      end
      if (cb == 128) phase = P_DONE;
    end else if (phase == P_DONE) begin
      m_done = 1; m_busy = 0; phase = P_IDLE;
    end
    @(posedge clk);
    #1;
    if (done_a) done_seen++;
    if (we_a) writes_seen++;
    chk("status_a", {123'd0, we_a, done_a, busy_a, ovf_a, dup_a}, {123'd0, m_we, m_done, m_busy, m_ovf, m_dup});
    chk("status_b", {123'd0, we_b, done_b, busy_b, ovf_b, dup_b}, {123'd0, m_we, m_done, m_busy, m_ovf, m_dup});
    chk("row_done_a", 128'(rowd_a), 128'(m_rowd));
    chk("row_done_b", 128'(rowd_b), 128'(m_rowd));
    if (m_we) begin
      chk("addr_a", 128'(addr_a), 128'(m_idx));
      chk("addr_b", 128'(addr_b), 128'(7'(m_idx + 7'd64)));
      chk("din_a", din_a, m_din);
      chk("din_b", din_b, m_din);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 2'd0, 5'd0, '0, rdy, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [6:0] idx;
    int         d0, w0;
    rst = 1; start = 0; in_valid = 0; O_mem_ready = 0; in_vec = '0; in_row = '0; in_tile = '0;
    model_clear(); m_busy = 0; phase = P_IDLE; m_we = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {addr_a, din_a, we_a, rowd_a, done_a, busy_a, ovf_a, dup_a},
        {7'd0, 128'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 0;

    // Idle: in_valid ignored
    step(1, 2'd1, 5'd3, rnd128(), 1, 0);
    idle(2, 1);

    // 1: in-order row-major stream, 1 vector per 8 cycles
    d0 = done_seen;
    step(0, 2'd0, 5'd0, '0, 1, 1);
    for (int k = 0; k < 128; k++) begin
      idx = 7'(k);
      step(1, idx[6:5], idx[4:0], rnd128(), 1, 0);
      chk("latency_we", 128'(we_a), 128'(1'b0));
      step(0, 2'd0, 5'd0, '0, 1, 0);
      chk("latency_we1", 128'(we_a), 128'(1'b1));
      idle(6, 1);
    end
    idle(4, 1);
    chk("t1_done_once", 128'(done_seen - d0), 128'd1);

    // 2: back-pressure burst of 6 into depth-4 FIFO
    step(0, 2'd0, 5'd0, '0, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 2'(k), 5'(k + 3), rnd128(), 0, 0);
    w0 = writes_seen;
    idle(10, 1);
    chk("t2_writes", 128'(writes_seen - w0), 128'd4);
    chk("t2_overflow", 128'(ovf_a), 128'd1);

    // 3: full FIFO with simultaneous pop and push
    step(0, 2'd0, 5'd0, '0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 2'd1, 5'(k), rnd128(), 0, 0);
    step(1, 2'd1, 5'd9, rnd128(), 1, 0);
    chk("t3_no_overflow", 128'(ovf_a), 128'd0);
    idle(8, 1);

    // 4: (2,7) sent twice, (2,8) held back
    d0 = done_seen;
    step(0, 2'd0, 5'd0, '0, 1, 1);
    for (int k = 0; k < 128; k++) begin
      idx = (k == 72) ? 7'd71 : 7'(k);
      step(1, idx[6:5], idx[4:0], rnd128(), 1, 0);
      step(0, 2'd0, 5'd0, '0, 1, 0);
    end
    idle(10, 1);
    chk("t4_no_done", 128'(done_seen - d0), 128'd0);
    chk("t4_dup", 128'(dup_a), 128'd1);
    step(1, 2'd2, 5'd8, rnd128(), 1, 0);
    idle(5, 1);
    chk("t4_done_after_missing", 128'(done_seen - d0), 128'd1);

    // Random traffic with occasional restarts
    step(0, 2'd0, 5'd0, '0, 1, 1);
    for (int k = 0; k < 600; k++)
      step(($urandom % 3) != 0, 2'($urandom), 5'($urandom), rnd128(),
           ($urandom % 4) != 0, ($urandom % 200) == 0);

    // 6: restart after 50 writes, start beats same-cycle in_valid
    step(0, 2'd0, 5'd0, '0, 1, 1);
    for (int k = 0; k < 50; k++) begin
      step(1, 2'(k / 32), 5'(k), rnd128(), 1, 0);
      step(0, 2'd0, 5'd0, '0, 1, 0);
    end
    step(1, 2'd3, 5'd3, rnd128(), 1, 1);
    idle(3, 1);

    // Async reset while a write is on the port
    for (int k = 0; k < 3; k++) step(1, 2'd0, 5'(k), rnd128(), 1, 0);
    chk("pre_reset_we", 128'(we_a), 128'd1);
    #1 rst = 1;
    #1;
    chk("async_reset_outs", {addr_a, din_a, we_a, rowd_a, done_a, busy_a, ovf_a, dup_a},
        {7'd0, 128'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 0;
    model_clear(); m_busy = 0; phase = P_IDLE;
    idle(3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
